filter_kernel_tap_accum: RTL and testbench



---
 rtl/filter_kernel_pkg.sv | 33 +++
 rtl/filter_kernel_valid_delay.sv | 35 +++
 rtl/filter_kernel_tap_accum.sv | 88 ++++++++
 tb/tb_filter_kernel_tap_accum.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_kernel_pkg.sv
// Shared widths, sideband type and the round/shift/saturate rule for the
// filter-kernel tap pipeline.
package filter_kernel_pkg;

  localparam int PROD_WIDTH = 61;
  localparam int ACC_WIDTH  = 64;
  localparam int OUT_WIDTH  = 8;
  localparam int SHIFT      = 8;

  typedef logic [OUT_WIDTH-1:0]        pixel_t;
  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  typedef struct packed {
    logic valid;
    logic sof;
  } side_t;

  // Round half up, drop SHIFT fraction bits, clamp to the unsigned pixel range.
  function automatic pixel_t round_shift_sat(input acc_t sum);
    acc_t biased;
    acc_t r;
    biased = sum + (acc_t'(1) <<< (SHIFT - 1));
    r      = biased >>> SHIFT;
    if (r[ACC_WIDTH-1]) begin
      return '0;
    end else if (|r[ACC_WIDTH-2:OUT_WIDTH]) begin
      return '1;
    end else begin
      return r[OUT_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/filter_kernel_valid_delay.sv
// Enabled shift register carrying {valid, sof} alongside a multiplier that
// has no sideband of its own.
module filter_kernel_valid_delay
  import filter_kernel_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic in_valid,
  input  logic in_sof,
  output logic out_valid,
  output logic out_sof
);

  side_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else if (en) begin
      stage_q[0] <= '{valid: in_valid, sof: in_sof};
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_valid = stage_q[DEPTH-1].valid;
  assign out_sof   = stage_q[DEPTH-1].sof;

endmodule

// File: rtl/filter_kernel_tap_accum.sv
// Accumulates NUM_TAPS multiplier products per pixel, rounds/saturates the sum
// and drives the multiplier clock enable so output backpressure stalls the pipe.
module filter_kernel_tap_accum
  import filter_kernel_pkg::*;
#(
  parameter int NUM_TAPS    = 9,
  parameter int MUL_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [PROD_WIDTH-1:0] prod,
  output logic                  ce_out,
  output logic [OUT_WIDTH-1:0]  pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready
);

  localparam int CNT_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

  logic             adv;
  logic             d_valid;
  logic             d_sof;
  logic             fire;
  logic             start;
  logic             tap_last;
  acc_t             acc_q;
  acc_t             prod_ext;
  acc_t             sum_next;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;

  // A held, unconsumed pixel is the only thing that may stall the pipeline.
  assign adv    = !(pix_valid && !pix_ready);
  assign ce_out = adv;

  filter_kernel_valid_delay #(
    .DEPTH (MUL_LATENCY)
  ) u_valid_delay (
    .clk       (clk),
    .reset     (reset),
    .en        (adv),
    .in_valid  (in_valid),
    .in_sof    (in_valid & in_sof),
    .out_valid (d_valid),
    .out_sof   (d_sof)
  );

  assign prod_ext = {{(ACC_WIDTH - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
  assign fire     = adv && d_valid;

  // A sof in the middle of a window restarts it, discarding the partial sum.
  always_comb begin
    start    = d_sof || (cnt_q == '0);
    sum_next = start ? prod_ext : acc_q + prod_ext;
    tap_last = start ? (NUM_TAPS == 1) : (cnt_q == LAST_TAP);
    if (tap_last) begin
      cnt_next = '0;
    end else if (start) begin
      cnt_next = CNT_W'(1);
    end else begin
      cnt_next = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
    end else begin
      if (fire) begin
        acc_q <= sum_next;
        cnt_q <= cnt_next;
      end
      if (fire && tap_last) begin
        pix_data  <= round_shift_sat(sum_next);
        pix_valid <= 1'b1;
      end else if (pix_valid && pix_ready) begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_filter_kernel_tap_accum.sv
// Scoreboard bench: a window-level reference model predicts each pixel at the
// moment its last tap is issued; a monitor compares at every output handshake.
module tb_filter_kernel_tap_accum;
  import filter_kernel_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_sof;
  logic [PROD_WIDTH-1:0] prod;
  logic                  ce_out;
  logic [OUT_WIDTH-1:0]  pix_data;
  logic                  pix_valid;
  logic                  pix_ready = 1'b1;

  filter_kernel_tap_accum #(
    .NUM_TAPS    (9),
    .MUL_LATENCY (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .prod      (prod),
    .ce_out    (ce_out),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  longint exp_q[$];
  longint win[$];
  int     seen_q[$];
  int     seen_cyc[$];
  longint op;
  longint p1;
  bit     fired;
  bit     ce_s;
  int     rdy_mode  = 0;
  int     stall_cnt = 0;
  int     pv_cnt    = 0;
  bit     last_stall = 0;
  logic [OUT_WIDTH-1:0] last_data;

  task automatic check(string name, longint got, longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic longint model_pix(longint s);
    longint r;
    r = (s + 128) >>> 8;
    if (r < 0) return 0;
    if (r > 255) return 255;
    return r;
  endfunction

  // Window model: the taps of the current window in a list; sof restarts it.
  task automatic model_tap(longint v, bit sof);
    longint s;
    if (sof) win.delete();
    win.push_back(v);
    if (win.size() == 9) begin
      s = 0;
      foreach (win[i]) s += win[i];
      exp_q.push_back(model_pix(s));
      win.delete();
    end
  endtask

  // One clock: inputs are stable from posedge+1, ce is sampled at negedge,
  // the behavioural multiplier (2 stages, ce-gated) advances at posedge.
  task automatic cycle();
    @(negedge clk);
    ce_s  = ce_out;
    fired = ce_out && in_valid && !reset;
    @(posedge clk);
    cyc++;
    #1;
    if (ce_s) begin
      prod = p1[PROD_WIDTH-1:0];
      p1   = in_valid ? op : {$urandom, $urandom};
    end
    if (reset) begin
      win.delete();
      exp_q.delete();
    end else if (fired) begin
      model_tap(op, in_sof);
    end
  endtask

  task automatic send(longint v, bit sof);
    bit done;
    done     = 0;
    in_valid = 1'b1;
    in_sof   = sof;
    op       = v;
    for (int i = 0; i < 200 && !done; i++) begin
      cycle();
      done = fired;
    end
    if (!done) check("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic drain();
    bit done;
    done     = 0;
    in_valid = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (exp_q.size() == 0 && !pix_valid) done = 1;
      else cycle();
    end
    check("drain_timeout", done, 1);
    check("drain_left", exp_q.size(), 0);
  endtask

  // Nine taps summing to s; optional bubbles inserted before tap bub_at.
  task automatic window_sum(longint s, int bub_at, int bub_n, output int start_cyc);
    start_cyc = 0;
    for (int t = 0; t < 9; t++) begin
      if (t == bub_at) idle(bub_n);
      send((t == 0) ? s - 56 : 64'sd7, t == 0);
      if (t == 0) start_cyc = cyc;
    end
  endtask

  task automatic window_256(output int start_cyc);
    start_cyc = 0;
    for (int t = 0; t < 9; t++) begin
      send(256, t == 0);
      if (t == 0) start_cyc = cyc;
    end
  endtask

  task automatic clear_seen();
    seen_q.delete();
    seen_cyc.delete();
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ($urandom_range(0, 3) != 0);
      default: pix_ready = (stall_cnt >= 5);
    endcase
  end

  always @(negedge clk) begin
    longint e;
    if (!reset) begin
      if (pix_valid) pv_cnt++;
      if (pix_valid && !pix_ready) begin
        check("ce_stall", ce_out, 0);
        if (last_stall) check("hold_data", pix_data, last_data);
        stall_cnt++;
      end else begin
        check("ce_run", ce_out, 1);
      end
      last_stall = pix_valid && !pix_ready;
      last_data  = pix_data;
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pix", pix_data, -1);
        end else begin
          e = exp_q.pop_front();
          check("pix_data", pix_data, e);
        end
        seen_q.push_back(int'(pix_data));
        seen_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sa, sb, sc, pv0;
    longint v;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    op       = 0;
    p1       = 0;
    prod     = '0;
    repeat (3) cycle();
    reset = 1'b0;
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_ce_out", ce_out, 1);

    // Basic window, latency and one-cycle valid
    clear_seen();
    pv0 = pv_cnt;
    window_256(sc);
    drain();
    check("basic_count", seen_q.size(), 1);
    if (seen_q.size() == 1) begin
      check("basic_value", seen_q[0], 9);
      check("basic_latency", seen_cyc[0] - sc, 10);
    end
    check("basic_valid_cycles", pv_cnt - pv0, 1);

    // Rounding and saturation boundaries
    clear_seen();
    window_sum(384, -1, 0, sa);
    window_sum(383, -1, 0, sa);
    window_sum(-129, -1, 0, sa);
    window_sum(65535, -1, 0, sa);
    window_sum(64'sd1 << 40, -1, 0, sa);
    drain();
    check("round_count", seen_q.size(), 5);
    if (seen_q.size() == 5) begin
      check("round_384", seen_q[0], 2);
      check("round_383", seen_q[1], 1);
      check("round_neg129", seen_q[2], 0);
      check("round_65535", seen_q[3], 255);
      check("round_2p40", seen_q[4], 255);
    end

    // Back-to-back windows, 27 continuous taps
    clear_seen();
    window_sum(2304, -1, 0, sa);
    window_sum(384, -1, 0, sa);
    window_sum(65535, -1, 0, sa);
    drain();
    check("b2b_count", seen_q.size(), 3);
    if (seen_q.size() == 3) begin
      check("b2b_v0", seen_q[0], 9);
      check("b2b_v1", seen_q[1], 2);
      check("b2b_v2", seen_q[2], 255);
      check("b2b_gap0", seen_cyc[1] - seen_cyc[0], 9);
      check("b2b_gap1", seen_cyc[2] - seen_cyc[1], 9);
    end

    // Bubbles delay the pixel by the bubble count only
    clear_seen();
    window_sum(2304, -1, 0, sa);
    drain();
    window_sum(2304, 4, 3, sb);
    drain();
    check("bub_count", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      check("bub_v0", seen_q[0], 9);
      check("bub_v1", seen_q[1], 9);
      check("bub_lat0", seen_cyc[0] - sa, 10);
      check("bub_lat1", seen_cyc[1] - sb, 13);
    end

    // Backpressure: pixel held for 5 cycles while the next window's tap waits
    clear_seen();
    stall_cnt = 0;
    rdy_mode  = 2;
    window_sum(2304, -1, 0, sa);
    window_sum(384, -1, 0, sa);
    drain();
    rdy_mode = 0;
    check("bp_stalled", stall_cnt >= 5, 1);
    check("bp_count", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      check("bp_v0", seen_q[0], 9);
      check("bp_v1", seen_q[1], 2);
    end

    // Resync: a partial window is dropped by a fresh sof
    clear_seen();
    for (int t = 0; t < 4; t++) send(1000, t == 0);
    window_256(sa);
    drain();
    check("resync_count", seen_q.size(), 1);
    if (seen_q.size() == 1) check("resync_value", seen_q[0], 9);

    // Reset mid-window with products in flight
    for (int t = 0; t < 5; t++) send(5000, t == 0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("mid_rst_pix_valid", pix_valid, 0);
    check("mid_rst_pix_data", pix_data, 0);
    check("mid_rst_ce_out", ce_out, 1);
    clear_seen();
    window_256(sa);
    drain();
    check("post_rst_count", seen_q.size(), 1);
    if (seen_q.size() == 1) check("post_rst_value", seen_q[0], 9);

    // Randomized traffic with random backpressure, bubbles and resyncs
    rdy_mode = 1;
    for (int w = 0; w < 60; w++) begin
      for (int t = 0; t < 9; t++) begin
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
        case ($urandom_range(0, 3))
          0:       v = {$urandom, $urandom};
          1:       v = -longint'($urandom_range(0, 400));
          default: v = longint'($urandom_range(0, 900));
        endcase
        if ($urandom_range(0, 3) == 0) v = v >>> 3;
        else v = longint'($signed(v[PROD_WIDTH-1:0]));
        send(v, (t == 0 && (w % 5) != 2) || ($urandom_range(0, 40) == 0));
      end
    end
    drain();
    rdy_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
